// File: rtl/sdram_rd_arbiter.sv
// Read-only SDRAM port arbiter: three level-held ROM requesters share one SDRAM read port.
// Optional ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed c0 > c1 > c2.
module sdram_rd_arbiter #(
    parameter int AW = 23,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c0_req,
    input  logic          c1_req,
    input  logic          c2_req,
    input  logic [AW-1:0] c0_addr,
    input  logic [AW-1:0] c1_addr,
    input  logic [AW-1:0] c2_addr,
    output logic          c0_valid,
    output logic          c1_valid,
    output logic          c2_valid,
    output logic [DW-1:0] c_data,
    output logic          sdr_req,
    output logic [AW-1:0] sdr_addr,
    input  logic [DW-1:0] sdr_data,
    input  logic          sdr_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        RETIRE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [1:0]    gnt_r;
    logic [1:0]    gnt_s;
    logic [1:0]    winner_s;
    logic [2:0]    req_s;
    logic [2:0]    valid_r;
    logic [2:0]    valid_s;
    logic          sdr_req_r;
    logic          sdr_req_s;
    logic [AW-1:0] sdr_addr_r;
    logic [AW-1:0] sdr_addr_s;
    logic [AW-1:0] win_addr_s;
    logic [DW-1:0] c_data_r;
    logic [DW-1:0] c_data_s;

    // Returns the first requesting client in search order p0, p1, p2.
    function automatic logic [1:0] first_req(input logic [2:0] req,
                                             input logic [1:0] p0,
                                             input logic [1:0] p1,
                                             input logic [1:0] p2);
        logic [1:0] w;
        if (req[p0]) begin
            w = p0;
        end else if (req[p1]) begin
            w = p1;
        end else begin
            w = p2;
        end
        return w;
    endfunction

    assign req_s = {c2_req, c1_req, c0_req};

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] rr_r;
    logic [1:0] rr_s;

    // Round-robin winner: search starts just after the last-served client.
    always_comb begin
        case (rr_r)
            2'd0:    winner_s = first_req(req_s, 2'd1, 2'd2, 2'd0);
            2'd1:    winner_s = first_req(req_s, 2'd2, 2'd0, 2'd1);
            default: winner_s = first_req(req_s, 2'd0, 2'd1, 2'd2);
        endcase
    end
`else
    // Fixed-priority winner: c0 over c1 over c2.
    always_comb begin
        winner_s = first_req(req_s, 2'd0, 2'd1, 2'd2);
    end
`endif

    // Address of the arbitration winner.
    always_comb begin
        case (winner_s)
            2'd0:    win_addr_s = c0_addr;
            2'd1:    win_addr_s = c1_addr;
            2'd2:    win_addr_s = c2_addr;
            default: win_addr_s = {AW{1'b0}};
        endcase
    end

    // Next-state and next-output logic for the grant/transfer/retire sequence.
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt_r;
        sdr_req_s  = sdr_req_r;
        sdr_addr_s = sdr_addr_r;
        c_data_s   = c_data_r;
        valid_s    = valid_r;
`ifdef ARB_ROUND_ROBIN_EN
        rr_s       = rr_r;
`endif
        case (state_r)
            IDLE: begin
                valid_s = 3'b000;
                // sdr_valid is deliberately not looked at here: stray pulses are dropped.
                if (|req_s) begin
                    gnt_s      = winner_s;
                    sdr_addr_s = win_addr_s;
                    sdr_req_s  = 1'b1;
                    state_s    = BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_s       = winner_s;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (sdr_valid) begin
                    sdr_req_s = 1'b0;
                    c_data_s  = sdr_data;
                    case (gnt_r)
                        2'd0:    valid_s = 3'b001;
                        2'd1:    valid_s = 3'b010;
                        2'd2:    valid_s = 3'b100;
                        default: valid_s = 3'b000;
                    endcase
                    state_s = RETIRE;
                end else begin
                    state_s = BUSY;
                end
            end
            RETIRE: begin
                valid_s = 3'b000;
                state_s = IDLE;
            end
            default: begin
                valid_s   = 3'b000;
                sdr_req_s = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            gnt_r      <= 2'd0;
            sdr_req_r  <= 1'b0;
            sdr_addr_r <= {AW{1'b0}};
            c_data_r   <= {DW{1'b0}};
            valid_r    <= 3'b000;
`ifdef ARB_ROUND_ROBIN_EN
            rr_r       <= 2'd0;
`endif
        end else begin
            state_r    <= state_s;
            gnt_r      <= gnt_s;
            sdr_req_r  <= sdr_req_s;
            sdr_addr_r <= sdr_addr_s;
            c_data_r   <= c_data_s;
            valid_r    <= valid_s;
`ifdef ARB_ROUND_ROBIN_EN
            rr_r       <= rr_s;
`endif
        end
    end

    assign sdr_req  = sdr_req_r;
    assign sdr_addr = sdr_addr_r;
    assign c_data   = c_data_r;
    assign c0_valid = valid_r[0];
    assign c1_valid = valid_r[1];
    assign c2_valid = valid_r[2];

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Self-checking bench for sdram_rd_arbiter (default fixed-priority build): vector table,
// scoreboard queue of expected completions, behavioural SDRAM and client models.
module tb_sdram_rd_arbiter;
    localparam int AW = 23;
    localparam int DW = 16;
    localparam int NV = 6;

    logic          clk;
    logic          reset;
    logic [2:0]    req_v;
    logic [AW-1:0] c0_addr, c1_addr, c2_addr;
    logic          c0_valid, c1_valid, c2_valid;
    logic [DW-1:0] c_data;
    logic          sdr_req;
    logic [AW-1:0] sdr_addr;
    logic [DW-1:0] sdr_data;
    logic          sdr_valid;
    logic [2:0]    vld;

    sdram_rd_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .c0_req(req_v[0]), .c1_req(req_v[1]), .c2_req(req_v[2]),
        .c0_addr(c0_addr), .c1_addr(c1_addr), .c2_addr(c2_addr),
        .c0_valid(c0_valid), .c1_valid(c1_valid), .c2_valid(c2_valid),
        .c_data(c_data), .sdr_req(sdr_req), .sdr_addr(sdr_addr),
        .sdr_data(sdr_data), .sdr_valid(sdr_valid)
    );

    assign vld = {c2_valid, c1_valid, c0_valid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            cli;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct packed {
        logic [2:0]             req;
        logic [2:0][AW-1:0]     a;
        int                     lat;
        int                     n;
        logic [2:0][1:0]        ord;
        logic [2:0][DW-1:0]     d;
    } vec_t;

    exp_t          sbq[$];
    vec_t          vecs[NV];
    int            n_pass;
    int            n_total;
    logic [DW-1:0] last_data;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic [2:0] req,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                           input int lat, input int n,
                           input logic [1:0] o0, input logic [1:0] o1, input logic [1:0] o2,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        vecs[i].req = req;
        vecs[i].a[0] = a0; vecs[i].a[1] = a1; vecs[i].a[2] = a2;
        vecs[i].lat = lat; vecs[i].n = n;
        vecs[i].ord[0] = o0; vecs[i].ord[1] = o1; vecs[i].ord[2] = o2;
        vecs[i].d[0] = d0; vecs[i].d[1] = d1; vecs[i].d[2] = d2;
    endtask

    // Runs until every queued completion has been seen. keep: clients that keep req high after
    // their valid; drop_cli: client that drops req one cycle into its transfer (-1 = none).
    task automatic run_sb(input int lat, input logic [2:0] keep, input int drop_cli, input bit idle_start);
        int   cyc, sd_cnt, budget, cli, valid_cyc;
        bit   sd_busy, have_last, first_rise;
        exp_t e;
        cyc = 0; sd_cnt = 0; sd_busy = 0; have_last = 0; first_rise = 1; valid_cyc = 0;
        budget = 40 * sbq.size() + 20;
        while (sbq.size() != 0 && cyc < budget) begin
            tick;
            cyc++;
            if (sd_busy && !sdr_valid) check("sdr_req_held", sdr_req, 1);
            if (vld != 3'b000) begin
                if (vld != 3'b001 && vld != 3'b010 && vld != 3'b100) check("valid_onehot", vld, 0);
                cli = c0_valid ? 0 : (c1_valid ? 1 : 2);
                if (sbq.size() == 0) begin
                    check("unexpected_valid", vld, 0);
                end else begin
                    e = sbq.pop_front();
                    check("client", cli, e.cli);
                    check("c_data", c_data, e.data);
                    last_data = e.data;
                end
                if (!keep[cli]) req_v[cli] = 1'b0;
                have_last = 1;
                valid_cyc = cyc;
            end
            // Behavioural SDRAM: respond lat cycles after sdr_req becomes visible.
            if (sdr_valid) begin
                sdr_valid = 1'b0;
                sd_busy = 0;
            end else begin
                if (!sd_busy && sdr_req) begin
                    sd_busy = 1;
                    sd_cnt = 0;
                    if (sbq.size() == 0) check("spurious_sdr_req", 1, 0);
                    else check("sdr_addr", sdr_addr, sbq[0].addr);
                    if (have_last) check("b2b_gap", cyc - valid_cyc, 2);
                    if (first_rise && idle_start && !have_last) check("grant_lat", cyc, 1);
                    first_rise = 0;
                end
                if (sd_busy) begin
                    sd_cnt++;
                    if (sd_cnt == 1 && drop_cli >= 0) req_v[drop_cli] = 1'b0;
                    if (sd_cnt >= lat) begin
                        sdr_valid = 1'b1;
                        sdr_data = (sbq.size() != 0) ? sbq[0].data : 16'h0000;
                    end
                end
            end
        end
        if (sbq.size() != 0) begin
            check("timeout_pending", sbq.size(), 0);
            sbq.delete();
        end
        sdr_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_v = 3'b000;
        c0_addr = '0; c1_addr = '0; c2_addr = '0;
        sdr_data = 16'h0000; sdr_valid = 1'b0;
        n_pass = 0; n_total = 0; last_data = 16'h0000;

        set_vec(0, 3'b001, 23'h001234, 23'h000000, 23'h000000, 4, 1, 2'd0, 2'd0, 2'd0, 16'hBEEF, 16'h0000, 16'h0000);
        set_vec(1, 3'b111, 23'h000100, 23'h200200, 23'h7FFFFF, 2, 3, 2'd0, 2'd1, 2'd2, 16'h1111, 16'h2222, 16'h3333);
        set_vec(2, 3'b110, 23'h000000, 23'h000ABC, 23'h7FFFFE, 1, 2, 2'd1, 2'd2, 2'd0, 16'hA5A5, 16'h5A5A, 16'h0000);
        set_vec(3, 3'b101, 23'h155555, 23'h000000, 23'h2AAAAA, 3, 2, 2'd0, 2'd2, 2'd0, 16'hFFFF, 16'h0000, 16'h0000);
        set_vec(4, 3'b011, 23'h000000, 23'h7FFFFF, 23'h000000, 5, 2, 2'd0, 2'd1, 2'd0, 16'h0001, 16'h8000, 16'h0000);
        set_vec(5, 3'b100, 23'h000000, 23'h000000, 23'h123456, 1, 1, 2'd2, 2'd0, 2'd0, 16'hC3C3, 16'h0000, 16'h0000);

        repeat (3) tick;
        reset = 1'b0;
        tick;
        check("rst_sdr_req", sdr_req, 0);
        check("rst_sdr_addr", sdr_addr, 0);
        check("rst_c_data", c_data, 0);
        check("rst_valids", vld, 0);

        for (int i = 0; i < NV; i++) begin
            c0_addr = vecs[i].a[0]; c1_addr = vecs[i].a[1]; c2_addr = vecs[i].a[2];
            for (int k = 0; k < vecs[i].n; k++)
                sbq.push_back('{cli: int'(vecs[i].ord[k]), addr: vecs[i].a[vecs[i].ord[k]], data: vecs[i].d[k]});
            req_v = vecs[i].req;
            run_sb(vecs[i].lat, 3'b000, -1, 1'b1);
            req_v = 3'b000;
            tick; tick;
            check("idle_sdr_req", sdr_req, 0);
        end

        // Early drop: c1 releases req one cycle into its transfer.
        c1_addr = 23'h3C3C3C;
        sbq.push_back('{cli: 1, addr: 23'h3C3C3C, data: 16'hABCD});
        req_v = 3'b010;
        run_sb(4, 3'b000, 1, 1'b1);
        req_v = 3'b000;
        tick; tick;

        // Fixed-priority starvation with c0 re-requesting continuously; then c2 once c0 stops.
        c0_addr = 23'h000010; c2_addr = 23'h7F0000;
        for (int i = 0; i < 10; i++)
            sbq.push_back('{cli: 0, addr: 23'h000010, data: 16'h1000 + 16'(i)});
        req_v = 3'b101;
        run_sb(2, 3'b001, -1, 1'b1);
        req_v[0] = 1'b0;
        sbq.push_back('{cli: 2, addr: 23'h7F0000, data: 16'h2222});
        run_sb(2, 3'b000, -1, 1'b0);
        req_v = 3'b000;
        tick; tick;

        // Reset two cycles into a transfer, with sdr_valid coincident and after.
        c0_addr = 23'h0ABCDE;
        req_v = 3'b001;
        tick;
        check("rstseq_req", sdr_req, 1);
        check("rstseq_addr", sdr_addr, 23'h0ABCDE);
        tick; tick;
        reset = 1'b1; req_v = 3'b000;
        sdr_valid = 1'b1; sdr_data = 16'hDEAD;
        tick;
        check("rstseq_req_low", sdr_req, 0);
        check("rstseq_addr0", sdr_addr, 0);
        check("rstseq_data0", c_data, 0);
        check("rstseq_valids", vld, 0);
        reset = 1'b0;
        tick;
        check("late_valid_ignored", vld, 0);
        check("late_data_ignored", c_data, 0);
        sdr_valid = 1'b0;
        tick;
        check("late_no_req", sdr_req, 0);
        check("late_valids", vld, 0);
        c0_addr = 23'h000777;
        sbq.push_back('{cli: 0, addr: 23'h000777, data: 16'h7777});
        req_v = 3'b001;
        run_sb(2, 3'b000, -1, 1'b1);
        req_v = 3'b000;
        tick; tick;

        // Stray sdr_valid while idle must be ignored.
        for (int i = 0; i < 3; i++) begin
            sdr_valid = 1'b1;
            sdr_data = 16'hF0F0 ^ 16'(i);
            tick;
            check("stray_valids", vld, 0);
            check("stray_c_data", c_data, last_data);
            check("stray_sdr_req", sdr_req, 0);
        end
        sdr_valid = 1'b0;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
